// File: rtl/unibus_pkg.sv
// Shared types and constants for the Unibus bus-grant arbiter.
// Grant vectors are one-hot, indexed by the GNT_* constants.
package unibus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_SACKED,
    ARB_MASTER
  } arb_state_t;

  localparam int GNT_HLT = 0;
  localparam int GNT_NPG = 1;
  localparam int GNT_BG7 = 2;
  localparam int GNT_BG6 = 3;
  localparam int GNT_BG5 = 4;
  localparam int GNT_BG4 = 5;
  localparam int NGNT    = 6;

  localparam int TIMEOUT_DFLT = 1000;

  typedef logic [NGNT-1:0] gnt_vec_t;

  typedef struct packed {
    logic [7:4] br;
    logic       npr;
    logic       hlt;
    logic       sack;
    logic       bbsy;
  } req_t;

  // Fixed-priority pick; BR levels only at an instruction boundary.
  function automatic gnt_vec_t pick(
    input req_t       r,
    input logic       cyc_idle,
    input logic       inst_end,
    input logic [2:0] pri
  );
    gnt_vec_t g;
    g = '0;
    priority case (1'b1)
      r.hlt && cyc_idle:
        g[GNT_HLT] = 1'b1;
      r.npr && cyc_idle:
        g[GNT_NPG] = 1'b1;
      r.br[7] && inst_end && (3'd7 > pri):
        g[GNT_BG7] = 1'b1;
      r.br[6] && inst_end && (3'd6 > pri):
        g[GNT_BG6] = 1'b1;
      r.br[5] && inst_end && (3'd5 > pri):
        g[GNT_BG5] = 1'b1;
      r.br[4] && inst_end && (3'd4 > pri):
        g[GNT_BG4] = 1'b1;
      default:
        g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/unibus_arbiter_if.sv
// Unibus arbitration signals between the backplane and the arbiter.
// master = arbiter side, slave = backplane/CPU side.
interface unibus_arbiter_if;

  logic [7:4] br_in_l;
  logic       npr_in_l;
  logic       hltrq_in_l;
  logic       sack_in_l;
  logic       bbsy_in_l;
  logic [2:0] cpu_pri;
  logic       cpu_cyc_idle;
  logic       cpu_inst_end;
  logic [7:4] bg_out_h;
  logic       npg_out_h;
  logic       hltgr_out_h;
  logic       cpu_hold;
  logic       grant_tmo;

  modport master (
    input  br_in_l,
    input  npr_in_l,
    input  hltrq_in_l,
    input  sack_in_l,
    input  bbsy_in_l,
    input  cpu_pri,
    input  cpu_cyc_idle,
    input  cpu_inst_end,
    output bg_out_h,
    output npg_out_h,
    output hltgr_out_h,
    output cpu_hold,
    output grant_tmo
  );

  modport slave (
    output br_in_l,
    output npr_in_l,
    output hltrq_in_l,
    output sack_in_l,
    output bbsy_in_l,
    output cpu_pri,
    output cpu_cyc_idle,
    output cpu_inst_end,
    input  bg_out_h,
    input  npg_out_h,
    input  hltgr_out_h,
    input  cpu_hold,
    input  grant_tmo
  );

endinterface

// File: rtl/unibus_arbiter_grant_timer.sv
// Loadable down-counter that stops at zero; bounds unacknowledged grants.
module grant_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/unibus_arbiter.sv
// Unibus bus-grant arbiter: one grant at a time, SACK/BBSY handover,
// and a timeout that withdraws grants nobody acknowledges.
module unibus_arbiter
  import unibus_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DFLT
) (
  input logic              CLOCK,
  input logic              RESET,
  unibus_arbiter_if.master bus
);

  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT - 1);

  req_t       req_q;
  arb_state_t state_q;
  gnt_vec_t   gnt_q;
  gnt_vec_t   win;
  gnt_vec_t   req_v;
  logic       hold_q;
  logic       tmo_q;
  logic       held;
  logic       tmr_load;
  logic       tmr_dec;
  logic       tmr_zero;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      req_q <= '0;
    end else begin
      req_q.br   <= ~bus.br_in_l;
      req_q.npr  <= ~bus.npr_in_l;
      req_q.hlt  <= ~bus.hltrq_in_l;
      req_q.sack <= ~bus.sack_in_l;
      req_q.bbsy <= ~bus.bbsy_in_l;
    end
  end

  assign req_v = {
    req_q.br[4],
    req_q.br[5],
    req_q.br[6],
    req_q.br[7],
    req_q.npr,
    req_q.hlt
  };

  always_comb begin
    win = pick(
      req_q,
      bus.cpu_cyc_idle,
      bus.cpu_inst_end,
      bus.cpu_pri
    );
    held     = |(gnt_q & req_v);
    tmr_load = (state_q == ARB_IDLE) && (|win);
    tmr_dec  = (state_q == ARB_GRANT);
  end

  grant_timer #(
    .W(16)
  ) u_timer (
    .clk      (CLOCK),
    .rst      (RESET),
    .load     (tmr_load),
    .load_val (TMO_LOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      hold_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      unique case (state_q)
        ARB_IDLE: begin
          if (|win) begin
            gnt_q   <= win;
            hold_q  <= 1'b1;
            state_q <= ARB_GRANT;
          end else begin
            hold_q  <= 1'b0;
          end
        end
        ARB_GRANT: begin
          // SACK outranks a simultaneous expiry.
          if (req_q.sack) begin
            gnt_q   <= '0;
            state_q <= ARB_SACKED;
          end else if (!held || tmr_zero) begin
            gnt_q   <= '0;
            hold_q  <= 1'b0;
            tmo_q   <= tmr_zero;
            state_q <= ARB_IDLE;
          end
        end
        ARB_SACKED: begin
          if (!req_q.sack) begin
            if (req_q.bbsy) begin
              state_q <= ARB_MASTER;
            end else begin
              hold_q  <= 1'b0;
              state_q <= ARB_IDLE;
            end
          end
        end
        ARB_MASTER: begin
          if (!req_q.bbsy) begin
            hold_q  <= 1'b0;
            state_q <= ARB_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.hltgr_out_h = gnt_q[GNT_HLT];
  assign bus.npg_out_h   = gnt_q[GNT_NPG];
  assign bus.bg_out_h    = {
    gnt_q[GNT_BG7],
    gnt_q[GNT_BG6],
    gnt_q[GNT_BG5],
    gnt_q[GNT_BG4]
  };
  assign bus.cpu_hold    = hold_q;
  assign bus.grant_tmo   = tmo_q;

endmodule

// File: tb/tb_unibus_arbiter.sv
// Scoreboard bench for unibus_arbiter: a behavioural model predicts
// each cycle's outputs; a monitor compares them after every edge.
module tb_unibus_arbiter;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  unibus_arbiter_if bus ();

  unibus_arbiter #(
    .TIMEOUT(TMO)
  ) dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus)
  );

  // stimulus, active high
  logic [7:4] br;
  logic       npr, hlt, sack, bbsy;
  logic       idle, iend;
  logic [2:0] pri;

  // model: who holds the grant (-1 none; 0 HLT, 1 NPR, 2..5 BR7..BR4)
  int         m_gnt;
  int         m_el;
  bit         m_sacked, m_master;
  logic [7:4] q_br;
  logic       q_npr, q_hlt, q_sack, q_bbsy;

  logic [7:0] exp_q[$];
  int         total = 0;
  int         bad = 0;

  function automatic void chk(
    input string      name,
    input logic [7:0] act,
    input logic [7:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b",
               name, $time, act, exp);
    end
  endfunction

  function automatic logic [7:0] dut_out();
    return {bus.bg_out_h, bus.npg_out_h,
            bus.hltgr_out_h, bus.cpu_hold,
            bus.grant_tmo};
  endfunction

  function automatic int level(input int k);
    return 9 - k;
  endfunction

  function automatic bit br_q_at(input int n);
    case (n)
      7: return q_br[7];
      6: return q_br[6];
      5: return q_br[5];
      default: return q_br[4];
    endcase
  endfunction

  function automatic bit req_of(input int k);
    if (k == 0) return q_hlt;
    if (k == 1) return q_npr;
    return br_q_at(level(k));
  endfunction

  function automatic bit eligible(input int k);
    if (k == 0) return q_hlt && idle;
    if (k == 1) return q_npr && idle;
    return br_q_at(level(k)) && iend &&
           (level(k) > int'(pri));
  endfunction

  task automatic mreset();
    m_gnt = -1; m_el = 0;
    m_sacked = 0; m_master = 0;
    q_br = '0; q_npr = 0; q_hlt = 0;
    q_sack = 0; q_bbsy = 0;
  endtask

  // drive inputs for the coming edge and queue its predicted outputs
  task automatic apply();
    logic [3:0] bgv;
    bit tmo;
    bus.br_in_l     = ~br;
    bus.npr_in_l    = ~npr;
    bus.hltrq_in_l  = ~hlt;
    bus.sack_in_l   = ~sack;
    bus.bbsy_in_l   = ~bbsy;
    bus.cpu_pri     = pri;
    bus.cpu_cyc_idle = idle;
    bus.cpu_inst_end = iend;
    tmo = 0;
    if (m_gnt >= 0) begin
      if (q_sack) begin
        m_gnt = -1;
        m_sacked = 1;
      end else begin
        m_el++;
        if (!req_of(m_gnt) || m_el == TMO) begin
          tmo = (m_el == TMO);
          m_gnt = -1;
        end
      end
    end else if (m_sacked) begin
      if (!q_sack) begin
        m_sacked = 0;
        m_master = q_bbsy;
      end
    end else if (m_master) begin
      if (!q_bbsy) m_master = 0;
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (eligible(k)) begin
          m_gnt = k;
          m_el = 0;
          break;
        end
      end
    end
    q_br = br; q_npr = npr; q_hlt = hlt;
    q_sack = sack; q_bbsy = bbsy;
    bgv = '0;
    case (m_gnt)
      2: bgv[3] = 1'b1;
      3: bgv[2] = 1'b1;
      4: bgv[1] = 1'b1;
      5: bgv[0] = 1'b1;
      default: bgv = '0;
    endcase
    exp_q.push_back({bgv, m_gnt == 1, m_gnt == 0,
                     m_gnt >= 0 || m_sacked || m_master,
                     tmo});
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      apply();
    end
  endtask

  task automatic pulse();
    iend = 1'b1;
    cyc();
    iend = 1'b0;
    cyc();
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst", dut_out(), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    mreset();
    apply();
  endtask

  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out", dut_out(), e);
      end
    end
  end

  initial begin : stim
    br = '0; npr = 0; hlt = 0; sack = 0; bbsy = 0;
    idle = 1; iend = 0; pri = 3'd0;
    rst = 1'b1;
    bus.br_in_l = '1;
    bus.npr_in_l = 1; bus.hltrq_in_l = 1;
    bus.sack_in_l = 1; bus.bbsy_in_l = 1;
    bus.cpu_pri = 0; bus.cpu_cyc_idle = 1;
    bus.cpu_inst_end = 0;
    #2;
    chk("reset_state", dut_out(), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    mreset();
    apply();

    // NPR grant and full handover
    npr = 1; cyc(4);
    sack = 1; cyc(4);
    npr = 0; sack = 0; bbsy = 1; cyc(4);
    bbsy = 0; cyc(3);

    // BR5 blocked by priority 5, then allowed at 4
    br[5] = 1; pri = 3'd5;
    for (int i = 0; i < 10; i++) pulse();
    pri = 3'd4; pulse(); cyc(2);
    sack = 1; cyc(3);
    br[5] = 0; sack = 0; cyc(3);

    // NPR and BR7 together: NPR first, BR7 after
    pri = 3'd0; npr = 1; br[7] = 1;
    iend = 1; cyc(); iend = 0; cyc(3);
    sack = 1; cyc(3);
    npr = 0; sack = 0; bbsy = 1; cyc(3);
    bbsy = 0; cyc(2);
    pulse(); cyc(2);
    br[7] = 0; cyc(3);

    // BR6 with no SACK times out, then re-granted
    br[6] = 1; cyc(); pulse(); cyc(TMO + 3);
    pulse(); cyc(3);

    // reset while BR6 is granted
    mid_reset();
    br[6] = 0; cyc(3);

    // BR4 withdrawn while granted
    br[4] = 1; cyc(); pulse(); cyc(2);
    br[4] = 0; cyc(4);

    // HLTRQ beats everything
    hlt = 1; npr = 1; br = 4'hF; iend = 1; cyc();
    iend = 0; cyc(3);
    hlt = 0; npr = 0; br = '0; cyc(3);

    // SACK and expiry in the same cycle
    br[7] = 1; cyc(); pulse(); cyc(TMO - 3);
    sack = 1; cyc(4);
    sack = 0; br[7] = 0; cyc(3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) br[7] = ~br[7];
      if ($urandom_range(0, 9) == 0) br[6] = ~br[6];
      if ($urandom_range(0, 9) == 0) br[5] = ~br[5];
      if ($urandom_range(0, 9) == 0) br[4] = ~br[4];
      if ($urandom_range(0, 11) == 0) npr = ~npr;
      if ($urandom_range(0, 29) == 0) hlt = ~hlt;
      if ($urandom_range(0, 5) == 0) sack = ~sack;
      if ($urandom_range(0, 5) == 0) bbsy = ~bbsy;
      if ($urandom_range(0, 15) == 0)
        pri = 3'($urandom_range(0, 7));
      idle = ($urandom_range(0, 3) != 0);
      iend = ($urandom_range(0, 3) == 0);
      if (i == 1500) begin
        mid_reset();
      end else begin
        cyc();
      end
    end

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d want=0",
               exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unibus_arbiter.md
# unibus_arbiter

Bus-grant arbiter for the simulated PDP-11/34 Unibus backplane, sitting beside the fake CPU and driving the BG7..BG4, NPG and HLTGR lines into the wire-ANDed bus. It samples the active-low request lines (HLTRQ, NPR, BR7..BR4) and the CPU's priority and cycle state. It then issues at most one grant at a time, completes the SACK handshake, and holds the CPU off the bus until the new master has taken over. A timer drops any grant that no device acknowledges.

## Interface
- TIMEOUT, 1000: cycles a grant may stay unacknowledged before it is dropped (10 us at 100 MHz); legal range 2..65535.
- CLOCK  in  1  100 MHz system clock; the only clock.
- RESET  in  1  asynchronous, active-high reset.
- br_in_l  in  4  bus BR7..BR4 [7:4], active low.
- npr_in_l  in  1  bus NPR, active low.
- hltrq_in_l  in  1  bus HLTRQ, active low.
- sack_in_l  in  1  bus SACK, active low.
- bbsy_in_l  in  1  bus BBSY, active low.
- cpu_pri  in  3  current PSW priority 0..7.
- cpu_cyc_idle  in  1  high when the CPU has no bus cycle in progress.
- cpu_inst_end  in  1  one-cycle pulse at an instruction boundary.
- bg_out_h  out  4  BG7..BG4 [7:4].
- npg_out_h  out  1  NPG.
- hltgr_out_h  out  1  HLTGR.
- cpu_hold  out  1  CPU must not start a new bus cycle.
- grant_tmo  out  1  one-cycle pulse when a grant times out.

## Operation
- All request, SACK and BBSY inputs are inverted and registered once (stage `req_q`) before use.
- State machine:
  - IDLE
    - Pick the highest eligible request, in priority order: HLTRQ (requires cpu_cyc_idle), then NPR (requires cpu_cyc_idle), then BR7..BR4.
    - BRn is eligible only if n > cpu_pri and cpu_inst_end is high in the same cycle.
    - On a winner: register the matching grant one-hot, load the timer, go to GRANT.
  - GRANT
    - Exactly one grant output is high.
    - If sack_q: clear the grant and go to SACKED.
    - Else if the granted request is negated, or the timer reaches 0: clear the grant and go to IDLE. A timer expiry also pulses grant_tmo.
  - SACKED
    - All grants are low.
    - Wait until sack_q is negated and bbsy_q is asserted (the new master owns the bus); then go to MASTER.
    - If sack_q is negated while bbsy_q is also negated, go to IDLE (device aborted).
  - MASTER
    - Wait for bbsy_q to be negated, then go to IDLE.
- cpu_hold = (state != IDLE).
- Grant outputs are registered, one-hot or all zero; two grants are never high together.
- The timer is a 16-bit down-counter, loaded with TIMEOUT-1 on entry to GRANT and decremented each GRANT cycle.
- A timeout does not latch an error; the request may win again on the next IDLE evaluation.

## Timing
- Reset values: state IDLE, all grants 0, cpu_hold 0, grant_tmo 0, timer 0, req_q all negated.
- Reset is asynchronous: grants drop immediately, even mid-grant.
- Latency from a request edge to its grant: 2 CLOCK edges (input register, then IDLE decision).
  - For BR, counted from the first cpu_inst_end that occurs while the request is registered.
- SACK to grant removal: 2 edges.
- Grant removal to return to IDLE: at least 1 edge.
- A new arbitration can happen in the same cycle IDLE is entered.
- Simultaneous events:
  - NPR and BR7 in the same cycle: NPG is granted.
  - HLTRQ with anything else: HLTGR is granted.
  - SACK and timer expiry in the same cycle: SACK wins, no grant_tmo.
- Request changes while in GRANT do not re-arbitrate: a higher request waits for IDLE.
- cpu_pri is sampled only in IDLE; it is ignored once a grant is out.

## Structure
- Package unibus_pkg holds:
  - the state enum (ARB_IDLE, ARB_GRANT, ARB_SACKED, ARB_MASTER);
  - the grant one-hot index constants (GNT_HLT, GNT_NPG, GNT_BG7..GNT_BG4);
  - the default TIMEOUT value.
- One sub-module, grant_timer: a loadable 16-bit down-counter with a zero flag and async reset.

## Test plan
- NPR asserted with cpu_cyc_idle=1 → npg_out_h high 2 edges later. SACK asserted → npg low 2 edges later. BBSY asserted, SACK negated → state MASTER. BBSY released → cpu_hold 0.
- br_in_l[5] asserted, cpu_pri=5 → no grant across 10 cpu_inst_end pulses. Set cpu_pri=4 → bg_out_h=4'b0010 after the next pulse.
- BR7 and NPR asserted in the same cycle → only npg_out_h. After the handshake completes, bg_out_h[7] is granted.
- BR6 granted with no SACK, TIMEOUT=8 → grant drops after 8 GRANT cycles and grant_tmo pulses once. Request still held → re-granted at the next cpu_inst_end.
- RESET asserted mid-GRANT → all grants 0 in the same cycle without a clock. After release, state is IDLE.
- BR4 request withdrawn while granted → bg_out_h[4] drops 2 edges later, no grant_tmo, state IDLE.
